// File: rtl/dual_port_ram_copy_engine_pkg.sv
// Shared encodings for the RAM copy/fill engine: operation modes and FSM states.
package dual_port_ram_copy_engine_pkg;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_LAST_WR = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/dual_port_sync_ram.sv
// 2^N x M dual-port synchronous RAM with registered read data on both ports.
module dual_port_sync_ram #(
    parameter int N = 6,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic [N-1:0] addr_a,
    input  logic         wr_a,
    input  logic [M-1:0] din_a,
    output logic [M-1:0] dout_a,
    input  logic [N-1:0] addr_b,
    input  logic         wr_b,
    input  logic [M-1:0] din_b,
    output logic [M-1:0] dout_b
);

    logic [M-1:0] mem [0:(2**N)-1];

    // A read colliding with a write to the same address returns the old word.
    always_ff @(posedge clk) begin
        if (wr_a) mem[addr_a] <= din_a;
        if (wr_b) mem[addr_b] <= din_b;
        dout_a <= mem[addr_a];
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/dual_port_ram_copy_engine.sv
// Block COPY (port A read -> port B write) / FILL (pattern -> port B) engine
// over a programmable, wrapping address range of a dual-port synchronous RAM.
module dual_port_ram_copy_engine
    import dual_port_ram_copy_engine_pkg::*;
#(
    parameter int N = 6,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] src_addr,
    input  logic [N-1:0] dst_addr,
    input  logic [N:0]   len,
    input  logic [M-1:0] pattern,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] ram_addr_a,
    output logic         ram_wr_a,
    output logic [M-1:0] ram_din_a,
    input  logic [M-1:0] ram_dout_a,
    output logic [N-1:0] ram_addr_b,
    output logic         ram_wr_b,
    output logic [M-1:0] ram_din_b
);

    // Control handshake: start is a one-cycle request honoured only in IDLE;
    // busy stays high until the final write has been issued, then done
    // pulses for exactly one cycle with busy low.
    localparam logic [N:0]   ONE_C = (N+1)'(1);
    localparam logic [N-1:0] ONE_A = N'(1);

    state_e       state_q, state_d;
    mode_e        mode_q;
    logic [N-1:0] src_q, dst_q;
    logic [N:0]   len_q, rd_cnt, wr_cnt;
    logic [M-1:0] pat_q;
    logic         rd_last;

    assign rd_last = (rd_cnt == len_q - ONE_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = (len == '0) ? ST_DONE : ST_READ;
            ST_READ:    if (rd_last) state_d = (mode_q == MODE_FILL) ? ST_DONE : ST_LAST_WR;
            ST_LAST_WR: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Port B controls are registered; COPY writes lag their read by one cycle
    // to absorb the RAM's registered read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_COPY;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            pat_q      <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            ram_addr_a <= '0;
            ram_addr_b <= '0;
            ram_wr_b   <= 1'b0;
        end else begin
            ram_wr_b <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && len != '0) begin
                        mode_q <= mode_e'(mode);
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        len_q  <= len;
                        pat_q  <= pattern;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        if (mode_e'(mode) == MODE_COPY) begin
                            ram_addr_a <= src_addr;
                        end else begin
                            ram_wr_b   <= 1'b1;
                            ram_addr_b <= dst_addr;
                            wr_cnt     <= ONE_C;
                        end
                    end
                end
                ST_READ: begin
                    if (!rd_last) rd_cnt <= rd_cnt + ONE_C;
                    if (mode_q == MODE_COPY) begin
                        ram_wr_b   <= 1'b1;
                        ram_addr_b <= dst_q + wr_cnt[N-1:0];
                        wr_cnt     <= wr_cnt + ONE_C;
                        if (!rd_last) ram_addr_a <= src_q + rd_cnt[N-1:0] + ONE_A;
                    end else if (!rd_last) begin
                        ram_wr_b   <= 1'b1;
                        ram_addr_b <= dst_q + wr_cnt[N-1:0];
                        wr_cnt     <= wr_cnt + ONE_C;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_din_b = '0;
        if (ram_wr_b) ram_din_b = (mode_q == MODE_COPY) ? ram_dout_a : pat_q;
    end

    assign busy      = (state_q == ST_READ) || (state_q == ST_LAST_WR);
    assign done      = (state_q == ST_DONE);
    assign ram_wr_a  = 1'b0;
    assign ram_din_a = '0;

endmodule

// File: tb/tb_dual_port_ram_copy_engine.sv
// Bench for dual_port_ram_copy_engine driving a real dual_port_sync_ram.
module tb_dual_port_ram_copy_engine;

    localparam int N     = 6;
    localparam int M     = 8;
    localparam int DEPTH = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT + RAM ----------------
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [N-1:0] src_addr = '0;
    logic [N-1:0] dst_addr = '0;
    logic [N:0]   len = '0;
    logic [M-1:0] pattern = '0;
    logic         busy, done, ram_wr_a, ram_wr_b;
    logic [N-1:0] ram_addr_a, ram_addr_b;
    logic [M-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;

    logic         ld_en = 1'b0;
    logic [N-1:0] ld_addr = '0;
    logic [M-1:0] ld_data = '0;
    logic [N-1:0] mem_addr_b;
    logic         mem_wr_b;
    logic [M-1:0] mem_din_b;

    assign mem_addr_b = ld_en ? ld_addr : ram_addr_b;
    assign mem_wr_b   = ld_en ? 1'b1    : ram_wr_b;
    assign mem_din_b  = ld_en ? ld_data : ram_din_b;

    dual_port_ram_copy_engine #(.N(N), .M(M)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
        .busy(busy), .done(done),
        .ram_addr_a(ram_addr_a), .ram_wr_a(ram_wr_a), .ram_din_a(ram_din_a),
        .ram_dout_a(ram_dout_a),
        .ram_addr_b(ram_addr_b), .ram_wr_b(ram_wr_b), .ram_din_b(ram_din_b)
    );

    dual_port_sync_ram #(.N(N), .M(M)) u_ram (
        .clk(clk),
        .addr_a(ram_addr_a), .wr_a(ram_wr_a), .din_a(ram_din_a), .dout_a(ram_dout_a),
        .addr_b(mem_addr_b), .wr_b(mem_wr_b), .din_b(mem_din_b), .dout_b(ram_dout_b)
    );

    // ---------------- model state ----------------
    logic [M-1:0] model [DEPTH];
    logic [M-1:0] snap  [DEPTH];
    int checks = 0;
    int failures = 0;
    bit tb_done = 1'b0;
    bit chk_en = 1'b0;
    bit op_valid = 1'b0;
    int op_mode, op_src, op_dst, op_len, op_pat;
    int start_cyc = 0;
    int busy_n, done_n, wr_n, done_k;
    int k, idx, ai;
    logic eb, ed, ew, ea;
    logic [M-1:0] exp_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_word(input int a, input logic [M-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = N'(a); ld_data = d;
        model[a] = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic mem_check(input string tag);
        for (int i = 0; i < DEPTH; i++) check(tag, u_ram.mem[i], model[i]);
    endtask

    // Apply the memory effect of a completed operation to the model.
    task automatic model_apply(input int m, input int s, input int d, input int l, input int p);
        snap = model;
        for (int i = 0; i < l; i++) begin
            if (m == 1) model[(d + i) % DEPTH] = M'(p);
            else        model[(d + i) % DEPTH] = snap[(s + i) % DEPTH];
        end
    endtask

    task automatic run_op(input int m, input int s, input int d, input int l, input int p,
                          input int restart_at);
        int dur;
        @(negedge clk);
        mode = m[0]; src_addr = N'(s); dst_addr = N'(d); len = (N+1)'(l); pattern = M'(p);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_mode = m; op_src = s; op_dst = d; op_len = l; op_pat = p;
        start_cyc = cyc; op_valid = 1'b1;
        dur = (l == 0) ? 1 : (m == 0) ? l + 2 : l + 1;
        for (int c = 1; c <= dur + 2; c++) begin
            if (c == restart_at) begin
                start = 1'b1; dst_addr = N'(10);
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        model_apply(m, s, d, l, p);
        mem_check("mem");
    endtask

    // ---------------- compare + stimulus ----------------
    initial begin
        fork
            begin : compare
                while (!tb_done) begin
                    @(negedge clk);
                    if (chk_en) begin
                        k = cyc - start_cyc + 1;
                        eb = 0; ed = 0; ew = 0; ea = 0; idx = 0; ai = 0;
                        if (op_valid) begin
                            if (k == 1) begin busy_n = 0; done_n = 0; wr_n = 0; done_k = -1; end
                            if (op_len == 0) begin
                                ed = (k == 1);
                            end else if (op_mode == 0) begin
                                eb = (k >= 1 && k <= op_len + 1);
                                ed = (k == op_len + 2);
                                ew = (k >= 2 && k <= op_len + 1);
                                idx = k - 2;
                                ea = (k >= 1 && k <= op_len);
                                ai = k - 1;
                            end else begin
                                eb = (k >= 1 && k <= op_len);
                                ed = (k == op_len + 1);
                                ew = eb;
                                idx = k - 1;
                            end
                        end
                        check("busy", busy, eb);
                        check("done", done, ed);
                        check("wr_b", ram_wr_b, ew);
                        check("wr_a", ram_wr_a, 0);
                        if (ew) begin
                            exp_din = (op_mode == 1) ? M'(op_pat) : model[(op_src + idx) % DEPTH];
                            check("addr_b", ram_addr_b, (op_dst + idx) % DEPTH);
                            check("din_b", ram_din_b, exp_din);
                        end
                        if (ea) check("addr_a", ram_addr_a, (op_src + ai) % DEPTH);
                        if (busy) busy_n++;
                        if (ram_wr_b) wr_n++;
                        if (done) begin done_n++; done_k = k; end
                    end
                end
            end
            begin : driver
                int m, s, d, l, p, dd;
                // reset state
                repeat (2) @(posedge clk);
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_wr_b", ram_wr_b, 0);
                check("rst_addr_a", ram_addr_a, 0);
                check("rst_addr_b", ram_addr_b, 0);
                check("rst_din_b", ram_din_b, 0);
                @(negedge clk);
                rst_n = 1'b1;
                chk_en = 1'b1;

                for (int i = 0; i < DEPTH; i++) load_word(i, M'($urandom_range(0, 255)));
                load_word(0, 8'h11); load_word(1, 8'h22); load_word(2, 8'h33);
                load_word(3, 8'h44); load_word(4, 8'h55); load_word(10, 8'h3C);

                // basic COPY
                run_op(0, 0, 32, 4, 0, 0);
                check("copy_done_k", done_k, 6);
                check("copy_busy_n", busy_n, 5);
                check("copy_wr_n", wr_n, 4);
                check("copy_m32", u_ram.mem[32], 8'h11);
                check("copy_m33", u_ram.mem[33], 8'h22);
                check("copy_m34", u_ram.mem[34], 8'h33);
                check("copy_m35", u_ram.mem[35], 8'h44);

                // FILL wrapping past the top of the RAM
                run_op(1, 0, 60, 8, 8'hA5, 0);
                check("fill_done_k", done_k, 9);
                check("fill_busy_n", busy_n, 8);
                check("fill_m63", u_ram.mem[63], 8'hA5);
                check("fill_m0", u_ram.mem[0], 8'hA5);
                check("fill_m3", u_ram.mem[3], 8'hA5);
                check("fill_m4", u_ram.mem[4], 8'h55);

                // len = 0 in both modes
                run_op(0, 5, 7, 0, 0, 0);
                check("len0c_done_k", done_k, 1);
                check("len0c_busy_n", busy_n, 0);
                check("len0c_wr_n", wr_n, 0);
                run_op(1, 0, 9, 0, 8'h77, 0);
                check("len0f_done_k", done_k, 1);
                check("len0f_wr_n", wr_n, 0);

                // second start while busy must be ignored
                run_op(0, 0, 32, 4, 0, 2);
                check("restart_done_n", done_n, 1);
                check("restart_m10", u_ram.mem[10], 8'h3C);

                // reset in the middle of a COPY len=8
                @(negedge clk);
                mode = 1'b0; src_addr = N'(0); dst_addr = N'(40); len = (N+1)'(8);
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                op_mode = 0; op_src = 0; op_dst = 40; op_len = 8; op_pat = 0;
                start_cyc = cyc; op_valid = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk_en = 1'b0;
                rst_n = 1'b0;
                #1;
                check("mid_rst_busy", busy, 0);
                check("mid_rst_wr_b", ram_wr_b, 0);
                check("mid_rst_done", done, 0);
                check("mid_rst_addr_b", ram_addr_b, 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                op_valid = 1'b0;
                chk_en = 1'b1;
                repeat (12) @(posedge clk);
                #1;
                model_apply(0, 0, 40, 2, 0);
                mem_check("mid_rst_mem");

                // randomized operations, restricted to supported overlap cases
                for (int t = 0; t < 24; t++) begin
                    m = $urandom_range(0, 1);
                    s = $urandom_range(0, DEPTH - 1);
                    d = $urandom_range(0, DEPTH - 1);
                    l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, DEPTH);
                    p = $urandom_range(0, 255);
                    dd = (d - s + DEPTH) % DEPTH;
                    if (m == 0 && dd >= 2 && dd < l) l = dd;
                    run_op(m, s, d, l, p, 0);
                end

                // full-RAM self copy
                for (int i = 0; i < DEPTH; i++) load_word(i, M'(i));
                run_op(0, 0, 0, 64, 0, 0);
                check("full_done_k", done_k, 66);
                check("full_wr_n", wr_n, 64);
                check("full_m63", u_ram.mem[63], 8'd63);

                repeat (2) @(posedge clk);
                tb_done = 1'b1;
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_copy_engine.md
Name: dual_port_ram_copy_engine

Overview:
Initiator-side controller for the 2^N x M dual-port synchronous RAM. It performs block COPY (reads on port A, writes on port B) or block FILL (writes a constant pattern on port B) over a programmable address range. It sits between the control path, which uses a start/busy/done handshake, and the RAM's two ports, and accounts for the RAM's one-cycle registered read latency.

Parameters:
N, 6, RAM address width (RAM depth 2^N)
M, 8, RAM word width in bits

Ports:
clk  input  1  rising-edge clock, shared with the RAM
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
mode  input  1  0 = COPY, 1 = FILL; captured at start
src_addr  input  N  COPY source base address; captured at start
dst_addr  input  N  destination base address; captured at start
len  input  N+1  word count, 0..2^N; captured at start
pattern  input  M  FILL word; captured at start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when an operation completes
ram_addr_a  output  N  RAM port A address
ram_wr_a  output  1  RAM port A write enable; tied 0 (port A is read-only)
ram_din_a  output  M  RAM port A write data; tied 0
ram_dout_a  input  M  RAM port A registered read data
ram_addr_b  output  N  RAM port B address
ram_wr_b  output  1  RAM port B write enable
ram_din_b  output  M  RAM port B write data

Behaviour:
- Reset (asynchronous, rst_n=0): state returns to IDLE; busy, done, ram_wr_b, ram_addr_a, ram_addr_b and ram_din_b all go to 0 immediately; all counters are cleared. Reset asserted mid-operation abandons the operation. Words already written stay written, no further writes occur, and done is not pulsed.
- FSM states: IDLE, READ, LAST_WR, DONE.
- IDLE: busy=0. When start=1 and len!=0: capture all operands, clear rd_cnt and wr_cnt, set busy=1, and go to READ. When start=1 and len=0: go to DONE, so done pulses on the next cycle and nothing is written.
- COPY timing, with the start edge as E0:
  - In the cycle after edge E0+i (i = 0..len-1), ram_addr_a = src+i.
  - In the cycle after edge E0+i+1, ram_wr_b=1, ram_addr_b = dst+i, ram_din_b = ram_dout_a.
  - READ lasts len cycles, then LAST_WR lasts 1 cycle for the final write.
  - The DONE cycle follows: done=1, busy=0, then return to IDLE.
  - Total: start edge to done pulse = len+2 cycles.
- FILL timing: no port-A reads. In READ cycle i, ram_wr_b=1, ram_addr_b = dst+i, ram_din_b = pattern. LAST_WR is skipped, so start edge to done pulse = len+1 cycles.
- busy is high in READ and LAST_WR and low in IDLE and DONE. start arriving while busy or in DONE is ignored.
- Addresses are computed modulo 2^N (wrap from 2^N-1 to 0). len=2^N covers the whole RAM.
- ram_wr_b is 0 in every cycle where no valid write is scheduled. ram_addr_a holds its last value outside READ.
- Overlapping COPY ranges are processed in strict ascending order, one word per cycle, with a one-cycle write lag.
  - Supported semantics: non-overlapping ranges, dst < src, and dst = src+1 all give exact memmove results.
  - dst > src+1 with overlap is unsupported and gives pipeline-order data.
- Counters rd_cnt and wr_cnt are N+1 bits wide. Terminal condition: rd_cnt == len_q-1 in READ.

Decomposition:
- Shared package holds the mode encodings (COPY=0, FILL=1) and the FSM state encodings (IDLE, READ, LAST_WR, DONE).
- No sub-module. The FSM, counters and address adders fit in one module.
- Bench instantiates dual_port_sync_ram with matching N and M alongside the engine.

Test Plan:
- Preload RAM[0..3]=11,22,33,44; COPY src=0 dst=32 len=4 → RAM[32..35]=11,22,33,44; done pulses exactly 6 cycles after the start edge; busy high for 5 cycles (READ plus LAST_WR).
- FILL dst=60 len=8 pattern=A5 → RAM[60..63] and RAM[0..3]=A5 (wrap); RAM[4] unchanged; done 9 cycles after start.
- len=0, either mode → ram_wr_b stays 0, busy never rises, done pulses once on the next cycle.
- Second start during busy (COPY len=4, restart at cycle 2 with dst=10) → ignored; only RAM[32..35] written; exactly one done pulse.
- rst_n low on cycle 3 of COPY len=8 → busy, ram_wr_b and done drop immediately; only the first two destination words are written; no done pulse after release.
- COPY len=64 src=0 dst=0 with RAM loaded with its own index → contents unchanged; done after 66 cycles.
